paralelo_serial_tx: RTL and testbench

Byte-to-bitstream transmitter for the PHY link; the transmit-side counterpart of the lane receiver. Accepts 8-bit words through a valid/ready handshake, buffers one word, and serializes MSB first on a single 32f bit clock, one word slot per 8 cycles. Any slot without payload carries the idle/comma character 0xBC. After reset it sends a fixed preamble of idle words so the far-end receiver can reach its active state.

---
 rtl/paralelo_serial_tx_pkg.sv | 12 +
 rtl/paralelo_serial_tx.sv | 103 ++++++++++
 tb/tb_paralelo_serial_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_pkg.sv
// Shared PHY definitions: the idle/comma character and the transmitter state encoding.
package paralelo_serial_tx_pkg;

  localparam logic [7:0] IDLE_CHAR = 8'hBC;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-bitstream transmitter: one-entry hold buffer, MSB-first serializer with 8-cycle word slots,
// and an idle preamble after reset so the far-end receiver can lock before payload flows.
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  parameter int SYNC_WORDS = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out,
  output logic       word_start
);

  tx_state_e   state_reg, state_next;
  logic [2:0]  bit_cnt_reg;
  logic [3:0]  sync_cnt_reg;
  logic [7:0]  hold_reg;
  logic        hold_valid_reg;
  logic [6:0]  shift_reg;
  logic        data_out_reg;
  logic        word_start_reg;

  logic        slot_boundary;
  logic        sync_done;
  logic        take_hold;
  logic [7:0]  slot_word;

  // bit_cnt resets to 7 so the first edge after release is already a slot boundary
  assign slot_boundary = (bit_cnt_reg == 3'd7);
  assign sync_done     = (sync_cnt_reg == 4'(SYNC_WORDS - 1));
  assign take_hold     = hold_valid_reg && (state_reg == ACTIVE);
  assign slot_word     = take_hold ? hold_reg : IDLE_CHAR;

  assign active_out = (state_reg == ACTIVE);
  assign ready_out  = active_out && !hold_valid_reg;
  assign data_out   = data_out_reg;
  assign word_start = word_start_reg;

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_reg <= RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RESET:   state_next = SYNC;
      SYNC:    if (slot_boundary && sync_done) state_next = ACTIVE;
      ACTIVE:  state_next = ACTIVE;
      default: state_next = RESET;
    endcase
  end

  // Counts idle words that have fully left the wire while in SYNC
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      sync_cnt_reg <= '0;
    end else if (state_reg == SYNC && slot_boundary) begin
      sync_cnt_reg <= sync_cnt_reg + 4'd1;
    end
  end

  // A boundary drain and a new acceptance can never coincide: ready_out is low while the hold is full
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
    end else if (valid_in && ready_out) begin
      hold_reg       <= data_in;
      hold_valid_reg <= 1'b1;
    end else if (slot_boundary && take_hold) begin
      hold_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      bit_cnt_reg    <= 3'd7;
      shift_reg      <= '0;
      data_out_reg   <= 1'b0;
      word_start_reg <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if (slot_boundary) begin
        data_out_reg   <= slot_word[7];
        shift_reg      <= slot_word[6:0];
        word_start_reg <= 1'b1;
      end else begin
        data_out_reg   <= shift_reg[6];
        shift_reg      <= {shift_reg[5:0], 1'b0};
        word_start_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench: accepted words are queued with their expected slot; the monitor deserializes
// every slot and compares it against the queue (or the idle character when nothing is due).
module tb_paralelo_serial_tx;

  localparam int SW = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active_out;
  logic       word_start;

  typedef struct {
    logic [7:0] word;
    int         acc;
    int         slot;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = -2;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] mon_word = '0;

  paralelo_serial_tx #(.SYNC_WORDS(SW)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .active_out (active_out),
    .word_start (word_start)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // cyc = index of the last edge counted from the reset-release edge (0); -1 after a reset edge
  always @(posedge clk_32f) begin
    if (reset_L === 1'b0) cyc <= -1;
    else                  cyc <= cyc + 1;
  end

  always @(negedge clk_32f) begin
    automatic logic [7:0] full;
    automatic logic       hold_full;
    automatic logic [7:0] exp_word;
    automatic int         slot;
    if (cyc == -1) begin
      check("rst_data_out", data_out, 0);
      check("rst_word_start", word_start, 0);
      check("rst_active", active_out, 0);
      check("rst_ready", ready_out, 0);
    end else if (cyc >= 0) begin
      check("word_start", word_start, (cyc % 8 == 0));
      check("active_out", active_out, (cyc >= 8 * SW));
      hold_full = 1'b0;
      foreach (sb_q[k]) begin
        if (sb_q[k].acc <= cyc && cyc < 8 * sb_q[k].slot) hold_full = 1'b1;
      end
      check("ready_out", ready_out, (cyc >= 8 * SW) && !hold_full);
      full = (cyc % 8 == 0) ? {7'b0, data_out} : {mon_word[6:0], data_out};
      mon_word <= full;
      if (cyc % 8 == 7) begin
        slot = cyc / 8;
        exp_word = IDLE;
        if (sb_q.size() > 0 && sb_q[0].slot == slot) begin
          exp_word = sb_q[0].word;
          void'(sb_q.pop_front());
          $display("slot %0d: payload %02h observed, expected %02h", slot, full, exp_word);
        end
        check("slot_word", full, exp_word);
      end
    end
  end

  task automatic go_idle();
    valid_in = 1'b0;
    data_in  = 8'($urandom);
  endtask

  // Must be called at least #1 away from a clock edge
  task automatic send(input logic [7:0] w);
    automatic int   n = 0;
    automatic exp_t e;
    data_in  = w;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && n < 64) begin
      @(negedge clk_32f);
      #1;
      n++;
    end
    check("accept_timeout", ready_out, 1);
    if (ready_out === 1'b1) begin
      e.word = w;
      e.acc  = cyc + 1;
      e.slot = (cyc + 1) / 8 + 1;
      sb_q.push_back(e);
      $display("accept %02h at edge %0d, due in slot %0d", w, e.acc, e.slot);
    end
    @(posedge clk_32f);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    automatic int n = 0;
    while (cyc != target && n < 2000) begin
      @(negedge clk_32f);
      n++;
    end
    check("wait_cyc", cyc, target);
    #1;
  endtask

  task automatic wait_mod(input int m);
    automatic int n = 0;
    do begin
      @(negedge clk_32f);
      n++;
    end while ((cyc < 0 || cyc % 8 != m) && n < 64);
    check("wait_mod", cyc % 8, m);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    go_idle();
    repeat (3) @(posedge clk_32f);
    #1 reset_L = 1'b1;

    // single word one cycle after active_out rises
    wait_cyc(8 * SW);
    send(8'h5A);
    go_idle();

    // offer on a slot-boundary edge with the hold empty
    repeat (16) @(negedge clk_32f);
    wait_mod(7);
    send(8'h3C);
    go_idle();

    // back-to-back with valid held high
    repeat (16) @(negedge clk_32f);
    wait_mod(4);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    go_idle();
    repeat (24) @(negedge clk_32f);

    // reset in bit cycle 3 of a payload slot with the hold register full
    wait_mod(4);
    send(8'h11);
    send(8'h22);
    go_idle();
    wait_mod(2);
    reset_L = 1'b0;
    sb_q.delete();
    @(posedge clk_32f);
    #1 reset_L = 1'b1;

    wait_cyc(8 * SW + 2);
    send(8'hFF);
    go_idle();
    repeat (32) @(negedge clk_32f);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
